// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the sequential shift-add multiplier
package mul_seq_pkg;

  localparam int MUL_W    = 32;
  localparam int MUL_ITER = 32;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_32bit.sv
// rtl/full_adder_32bit.sv - 32-bit adder with carry in and carry out
module full_adder_32bit (
  input  logic [31:0] A_i,
  input  logic [31:0] Y_i,
  input  logic        C_i,
  output logic [31:0] Sum_o,
  output logic        c_o
);

  // 33-bit sum so the carry out lands in the top bit
  always_comb begin
    {c_o, Sum_o} = {1'b0, A_i} + {1'b0, Y_i} + {32'd0, C_i};
  end

endmodule

// File: rtl/mul_shift_add_seq.sv
// rtl/mul_shift_add_seq.sv - sequential 32x32 shift-add multiplier; optional MUL_ZERO_BYPASS_EN
module mul_shift_add_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  state_e             state_q, state_d;
  logic [MUL_W-1:0]   mcand_q;
  logic [MUL_W-1:0]   acc_q;
  logic [MUL_W-1:0]   mpl_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [MUL_W-1:0]   addend;
  logic [MUL_W-1:0]   sum;
  logic               carry;
  logic               accept;

`ifdef MUL_ZERO_BYPASS_EN
  logic               zero_op;
  assign zero_op = (a_i == '0) || (b_i == '0);
`endif

  // Partial product: add the multiplicand only when the current multiplier bit is set
  assign addend = mpl_q[0] ? mcand_q : '0;

  full_adder_32bit u_adder (
    .A_i   (acc_q),
    .Y_i   (addend),
    .C_i   (1'b0),
    .Sum_o (sum),
    .c_o   (carry)
  );

  assign product_o = {acc_q, mpl_q};

  // Handshake outputs decoded from state; next state with flush taking priority
  always_comb begin
    state_d     = state_q;
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
    accept      = in_valid_i & in_ready_o & ~flush_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MUL_ZERO_BYPASS_EN
          state_d = zero_op ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load operands on accept, then shift the adder result right one bit per RUN cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      mcand_q <= a_i;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef MUL_ZERO_BYPASS_EN
      mpl_q   <= zero_op ? '0 : b_i;
`else
      mpl_q   <= b_i;
`endif
    end else if (state_q == RUN && !flush_i) begin
      acc_q <= {carry, sum[MUL_W-1:1]};
      mpl_q <= {sum[0], mpl_q[MUL_W-1:1]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_shift_add_seq.sv
// tb/tb_mul_shift_add_seq.sv - scoreboard bench for mul_shift_add_seq; honours MUL_ZERO_BYPASS_EN
module tb_mul_shift_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [63:0] sb[$];
  logic        busy_ok;

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 32;
`endif

  always #5 clk = ~clk;

  mul_shift_add_seq #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .product_o   (product),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input bit push);
    int n;
    n = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    if (push) sb.push_back({32'd0, a} * {32'd0, b});
  endtask

  task automatic wait_valid(input string tag, input int exp_lat, output logic bok);
    int cyc;
    cyc = 0;
    bok = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (!busy) bok = 1'b0;
      step();
      cyc++;
    end
    check($sformatf("%s_latency", tag), 64'(cyc), 64'(exp_lat));
  endtask

  task automatic consume(input string tag, input int hold);
    logic [63:0] exp;
    logic [63:0] snap;
    logic        stable;
    exp = '0;
    check($sformatf("%s_sb_nonempty", tag), sb.size() != 0, 1);
    if (sb.size() != 0) exp = sb.pop_front();
    check($sformatf("%s_product", tag), product, exp);
    snap   = product;
    stable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!out_valid || in_ready || product !== snap) stable = 1'b0;
    end
    if (hold > 0) check($sformatf("%s_held", tag), stable, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("%s_valid_drop", tag), out_valid, 0);
    check($sformatf("%s_ready_back", tag), in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 3*5 with busy held through RUN
    accept(32'd3, 32'd5, 1'b1);
    check("small_busy_after_accept", busy, 1);
    wait_valid("small", 32, busy_ok);
    check("small_busy", busy_ok, 1);
    check("small_const", product, 64'h0000_0000_0000_000F);
    consume("small", 0);

    // All-ones operands exercise the adder carry into acc[31]
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_valid("ones", 32, busy_ok);
    check("ones_const", product, 64'hFFFF_FFFE_0000_0001);
    consume("ones", 0);

    // Backpressure for 10 cycles
    accept(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_valid("bp", 32, busy_ok);
    check("bp_const", product, 64'h0B00_EA4E_242D_2080);
    check("bp_in_ready_low", in_ready, 0);
    consume("bp", 10);

    // Flush at RUN iteration 10 with a competing operand
    accept(32'd11, 32'd13, 1'b0);
    for (int i = 0; i < 10; i++) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    a_in     = 32'd99;
    b_in     = 32'd99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    step();
    step();
    check("flush_not_taken", busy, 0);
    accept(32'd7, 32'd6, 1'b1);
    wait_valid("after_flush", 32, busy_ok);
    check("after_flush_const", product, 64'd42);
    consume("after_flush", 0);

    // Asynchronous reset mid-RUN
    accept(32'd5, 32'd5, 1'b0);
    for (int i = 0; i < 15; i++) step();
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_product", product, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    accept(32'd2, 32'd2, 1'b1);
    wait_valid("after_rst", 32, busy_ok);
    consume("after_rst", 0);

    // Flush and out_ready together in DONE: flush wins, result dropped
    accept(32'd4, 32'd4, 1'b0);
    wait_valid("flush_done", 32, busy_ok);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_ready", in_ready, 1);

    // Zero operands: bypass depends on the build
    accept(32'd0, 32'd9, 1'b1);
    wait_valid("zero_a", ZERO_LAT, busy_ok);
    consume("zero_a", 2);
    accept(32'd9, 32'd0, 1'b1);
    wait_valid("zero_b", ZERO_LAT, busy_ok);
    consume("zero_b", 0);

    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
